// File: rtl/fetch_controller.sv
// Instruction fetch controller: issues word reads to instruction memory and
// presents each fetched word with its address to decode via a valid/ready handshake.
module fetch_controller #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_out,
  output logic [31:0] instr_pc
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam logic [31:0] PC_INIT = {RESET_PC[31:2], 2'b00};

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        req_q, req_d;
  logic [31:0] addr_q, addr_d;
  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] ipc_q, ipc_d;
  logic        started_q, started_d;

  logic [31:0] redir_pc;
  logic        transfer;

  assign redir_pc = {redirect_pc[31:2], 2'b00};
  assign transfer = valid_q && instr_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pc_q      <= PC_INIT;
      req_q     <= 1'b0;
      addr_q    <= '0;
      valid_q   <= 1'b0;
      instr_q   <= '0;
      ipc_q     <= '0;
      started_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      req_q     <= req_d;
      addr_q    <= addr_d;
      valid_q   <= valid_d;
      instr_q   <= instr_d;
      ipc_q     <= ipc_d;
      started_q <= started_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    req_d     = req_q;
    addr_d    = addr_q;
    valid_d   = valid_q;
    instr_d   = instr_q;
    ipc_d     = ipc_q;
    started_d = 1'b1;

    unique case (state_q)
      IDLE: begin
        valid_d = 1'b0;
        req_d   = 1'b0;
        if (redirect_valid) begin
          pc_d = redir_pc;
        end
        // The first edge after reset release only arms started_q, so IDLE
        // occupies one full cycle and the first request follows the second edge.
        if (started_q) begin
          state_d = REQ;
          req_d   = 1'b1;
          addr_d  = pc_d;
        end
      end

      REQ: begin
        if (redirect_valid && imem_ack) begin
          pc_d    = redir_pc;
          addr_d  = redir_pc;
          req_d   = 1'b1;
          state_d = REQ;
        end else if (redirect_valid) begin
          // Issued request stays on the bus unchanged until its ack arrives.
          pc_d    = redir_pc;
          state_d = DRAIN;
        end else if (imem_ack) begin
          instr_d = imem_rdata;
          ipc_d   = pc_q;
          pc_d    = pc_q + 32'd4;
          valid_d = 1'b1;
          req_d   = 1'b0;
          state_d = HOLD;
        end
      end

      HOLD: begin
        if (redirect_valid) begin
          pc_d    = redir_pc;
          valid_d = 1'b0;
          req_d   = 1'b1;
          addr_d  = redir_pc;
          state_d = REQ;
        end else if (transfer) begin
          valid_d = 1'b0;
          req_d   = 1'b1;
          addr_d  = pc_q;
          state_d = REQ;
        end
      end

      DRAIN: begin
        if (redirect_valid) begin
          pc_d = redir_pc;
        end
        if (imem_ack) begin
          req_d   = 1'b1;
          addr_d  = pc_d;
          state_d = REQ;
        end
      end

      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
        valid_d = 1'b0;
      end
    endcase
  end

  assign imem_req    = req_q;
  assign imem_addr   = addr_q;
  assign instr_valid = valid_q;
  assign instr_out   = instr_q;
  assign instr_pc    = ipc_q;

endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller; memory returns {addr[15:0],16'hC0DE}.
module tb_fetch_controller;

  logic        clk;
  logic        rst_n;
  logic        imem_req, imem_ack, redirect_valid, instr_valid, instr_ready;
  logic [31:0] imem_addr, imem_rdata, redirect_pc, instr_out, instr_pc;

  logic        req2, valid2;
  logic [31:0] addr2, rdata2, out2, ipc2;

  int unsigned n_total;
  int unsigned n_bad;

  fetch_controller dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr_out     (instr_out),
    .instr_pc      (instr_pc)
  );

  fetch_controller #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_req      (req2),
    .imem_addr     (addr2),
    .imem_ack      (1'b1),
    .imem_rdata    (rdata2),
    .redirect_valid(1'b0),
    .redirect_pc   (32'h0),
    .instr_valid   (valid2),
    .instr_ready   (1'b1),
    .instr_out     (out2),
    .instr_pc      (ipc2)
  );

  assign imem_rdata = {imem_addr[15:0], 16'hC0DE};
  assign rdata2     = {addr2[15:0], 16'hC0DE};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_o(input string tag, input logic req, input logic [31:0] addr,
                          input logic vld, input logic [31:0] ipc, input logic [31:0] out);
    check({tag, ".req"},   {31'b0, imem_req},    {31'b0, req});
    check({tag, ".addr"},  imem_addr,            addr);
    check({tag, ".valid"}, {31'b0, instr_valid}, {31'b0, vld});
    check({tag, ".pc"},    instr_pc,             ipc);
    check({tag, ".out"},   instr_out,            out);
  endtask

  initial begin
    n_total        = 0;
    n_bad          = 0;
    rst_n          = 1'b1;
    imem_ack       = 1'b0;
    instr_ready    = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    #1 rst_n = 1'b0;
    tick();
    tick();
    expect_o("rst", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);

    // Sequential fetch with zero-wait memory
    imem_ack = 1'b1;
    @(negedge clk) rst_n = 1'b1;
    tick();
    expect_o("idle", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    check("w.req_idle", {31'b0, req2}, 32'd0);
    tick();
    expect_o("req0", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);
    check("w.addr0", addr2, 32'hFFFF_FFFC);
    tick();
    expect_o("hold0", 1'b0, 32'h0, 1'b1, 32'h0, 32'h0000_C0DE);
    check("w.ipc0", ipc2, 32'hFFFF_FFFC);
    check("w.out0", out2, 32'hFFFC_C0DE);
    tick();
    expect_o("req4", 1'b1, 32'h4, 1'b0, 32'h0, 32'h0000_C0DE);
    check("w.addr1", addr2, 32'h0000_0000);
    tick();
    expect_o("hold4", 1'b0, 32'h4, 1'b1, 32'h4, 32'h0004_C0DE);
    tick();
    expect_o("req8", 1'b1, 32'h8, 1'b0, 32'h4, 32'h0004_C0DE);
    tick();
    expect_o("hold8", 1'b0, 32'h8, 1'b1, 32'h8, 32'h0008_C0DE);

    // Decode stall for 5 cycles
    instr_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      expect_o($sformatf("stall%0d", i), 1'b0, 32'h8, 1'b1, 32'h8, 32'h0008_C0DE);
    end
    instr_ready = 1'b1;
    imem_ack    = 1'b0;

    // Memory wait: ack on the third request cycle
    tick();
    expect_o("wait1", 1'b1, 32'hC, 1'b0, 32'h8, 32'h0008_C0DE);
    tick();
    expect_o("wait2", 1'b1, 32'hC, 1'b0, 32'h8, 32'h0008_C0DE);
    tick();
    expect_o("wait3", 1'b1, 32'hC, 1'b0, 32'h8, 32'h0008_C0DE);
    imem_ack = 1'b1;
    tick();
    expect_o("holdC", 1'b0, 32'hC, 1'b1, 32'hC, 32'h000C_C0DE);
    imem_ack = 1'b0;
    tick();
    expect_o("req10", 1'b1, 32'h10, 1'b0, 32'hC, 32'h000C_C0DE);

    // Redirect against an unacked request -> DRAIN
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_1003;
    tick();
    expect_o("drain1", 1'b1, 32'h10, 1'b0, 32'hC, 32'h000C_C0DE);
    redirect_valid = 1'b0;
    tick();
    expect_o("drain2", 1'b1, 32'h10, 1'b0, 32'hC, 32'h000C_C0DE);
    imem_ack = 1'b1;
    tick();
    expect_o("req1000", 1'b1, 32'h1000, 1'b0, 32'hC, 32'h000C_C0DE);
    tick();
    expect_o("hold1000", 1'b0, 32'h1000, 1'b1, 32'h1000, 32'h1000_C0DE);

    // Redirect while holding a word
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_2000;
    instr_ready    = 1'b0;
    tick();
    expect_o("redirHold", 1'b1, 32'h2000, 1'b0, 32'h1000, 32'h1000_C0DE);

    // Redirect coinciding with ack: returned word is dropped
    redirect_pc = 32'h0000_3002;
    tick();
    expect_o("redirAck", 1'b1, 32'h3000, 1'b0, 32'h1000, 32'h1000_C0DE);
    redirect_valid = 1'b0;
    tick();
    expect_o("hold3000", 1'b0, 32'h3000, 1'b1, 32'h3000, 32'h3000_C0DE);
    instr_ready = 1'b1;
    tick();
    expect_o("req3004", 1'b1, 32'h3004, 1'b0, 32'h3000, 32'h3000_C0DE);

    // Asynchronous reset while draining
    imem_ack       = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_4000;
    tick();
    expect_o("drain3004", 1'b1, 32'h3004, 1'b0, 32'h3000, 32'h3000_C0DE);
    redirect_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    expect_o("asyncRst", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    imem_ack = 1'b1;
    @(negedge clk) rst_n = 1'b1;
    tick();
    expect_o("idleB", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    tick();
    expect_o("restart", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);
    tick();
    expect_o("restartHold", 1'b0, 32'h0, 1'b1, 32'h0, 32'h0000_C0DE);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
